// File: rtl/i2s_pkg.sv
// Shared types, default parameters and helpers for the I2S transmit/receive blocks.
package i2s_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned SLOT_W   = 32;
    localparam int unsigned SCLK_DIV = 4;

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    // Position of a bit counter value inside its channel slot.
    function automatic int unsigned slot_pos(input int unsigned bit_cnt,
                                             input int unsigned slot_w = SLOT_W);
        return bit_cnt % slot_w;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S serial timing: divides clk into SCLK, walks the bit counter across both
// slots and flags SCLK falling edges and the sample-capture cycle.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned  SLOT_W   = i2s_pkg::SLOT_W,
    parameter int unsigned  SCLK_DIV = i2s_pkg::SCLK_DIV,
    localparam int unsigned DIV_W    = $clog2(SCLK_DIV),
    localparam int unsigned BIT_W    = $clog2(2 * SLOT_W)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             sclk_o,
    output logic             lrclk_o,
    output logic             fall_o,
    output logic             cap_o,
    output logic [BIT_W-1:0] bit_nxt_o
);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(2 * SLOT_W - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sclk_q, lrclk_q, cap_q;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == DIV_MAX);
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        if (wrap) begin
            bit_cnt_d = (bit_cnt_q == BIT_MAX) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up with the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= (div_cnt_d >= DIV_HALF);
            if (wrap) begin
                lrclk_q <= (bit_cnt_d >= BIT_W'(SLOT_W));
            end
            cap_q     <= (div_cnt_d == DIV_MAX) && (bit_cnt_d == BIT_MAX);
        end
    end

    assign sclk_o    = sclk_q;
    assign lrclk_o   = lrclk_q;
    assign fall_o    = wrap;
    assign cap_o     = cap_q;
    assign bit_nxt_o = bit_cnt_d;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: captures a left/right sample pair once per frame and
// shifts it out MSB-first with one-bit delay. `I2S_TX_MUTE_EN adds a mute input.
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W   = i2s_pkg::DATA_W,
    parameter int unsigned SLOT_W   = i2s_pkg::SLOT_W,
    parameter int unsigned SCLK_DIV = i2s_pkg::SCLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
`ifdef I2S_TX_MUTE_EN
    input  logic              mute,
`endif
    output logic              SCLK,
    output logic              LRCLK,
    output logic              SDout,
    output logic              frame_strobe
);

    localparam int unsigned BIT_W = $clog2(2 * SLOT_W);

    logic             fall, cap;
    logic [BIT_W-1:0] bit_nxt;

    i2s_clk_gen #(
        .SLOT_W   (SLOT_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .sclk_o    (SCLK),
        .lrclk_o   (LRCLK),
        .fall_o    (fall),
        .cap_o     (cap),
        .bit_nxt_o (bit_nxt)
    );

    logic [DATA_W-1:0] lft_hold_q, lft_hold_d;
    logic [DATA_W-1:0] rht_hold_q, rht_hold_d;
    logic [DATA_W-1:0] word, word_sh;
    logic              sdout_q, sdout_d;
    int unsigned       pos;
    slot_e             slot;

    always_comb begin
        lft_hold_d = lft_hold_q;
        rht_hold_d = rht_hold_q;
        if (cap) begin
`ifdef I2S_TX_MUTE_EN
            lft_hold_d = mute ? '0 : lft_in;
            rht_hold_d = mute ? '0 : rht_in;
`else
            lft_hold_d = lft_in;
            rht_hold_d = rht_in;
`endif
        end
    end

    // SDout is computed for the bit position the counter enters at this fall event.
    always_comb begin
        pos     = slot_pos(32'(bit_nxt), SLOT_W);
        slot    = (bit_nxt >= BIT_W'(SLOT_W)) ? SLOT_RIGHT : SLOT_LEFT;
        word    = (slot == SLOT_RIGHT) ? rht_hold_q : lft_hold_q;
        word_sh = word << (pos - 1);
        sdout_d = sdout_q;
        if (fall) begin
            sdout_d = (pos >= 1 && pos <= DATA_W) ? word_sh[DATA_W-1] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_hold_q <= '0;
            rht_hold_q <= '0;
            sdout_q    <= 1'b0;
        end else begin
            lft_hold_q <= lft_hold_d;
            rht_hold_q <= rht_hold_d;
            sdout_q    <= sdout_d;
        end
    end

    assign SDout        = sdout_q;
    assign frame_strobe = cap;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx against a cycle-index arithmetic model of the I2S frame.
module tb_i2s_dac_tx;
    import i2s_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned SW    = 32;
    localparam int unsigned SD    = 4;
    localparam int unsigned FRAME = 2 * SW * SD;
    localparam logic [2*SW-1:0] PAT = {1'b0, 16'hA5C3, 15'h0000, 1'b0, 16'h8001, 15'h0000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    sample_t     lft_in = '0;
    sample_t     rht_in = '0;
    logic        mute_v = 1'b0;
    logic        SCLK, LRCLK, SDout, frame_strobe;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned k     = 0;
    sample_t     fr_l[$];
    sample_t     fr_r[$];

    i2s_dac_tx #(
        .DATA_W   (DW),
        .SLOT_W   (SW),
        .SCLK_DIV (SD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lft_in       (lft_in),
        .rht_in       (rht_in),
`ifdef I2S_TX_MUTE_EN
        .mute         (mute_v),
`endif
        .SCLK         (SCLK),
        .LRCLK        (LRCLK),
        .SDout        (SDout),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    // Reference: k = clk edges since reset release; frame f transmits the pair captured
    // at the last cycle of frame f-1 (zeros for frame 0).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 0;
            fr_l.delete();
            fr_r.delete();
            fr_l.push_back('0);
            fr_r.push_back('0);
        end else begin
            if (k % FRAME == FRAME - 1) begin
`ifdef I2S_TX_MUTE_EN
                fr_l.push_back(mute_v ? '0 : lft_in);
                fr_r.push_back(mute_v ? '0 : rht_in);
`else
                fr_l.push_back(lft_in);
                fr_r.push_back(rht_in);
`endif
            end
            k <= k + 1;
        end
    end

    function automatic logic exp_sd(int unsigned kk);
        int unsigned b = (kk / SD) % (2 * SW);
        int unsigned p = b % SW;
        int unsigned f = kk / FRAME;
        sample_t     w;
        if (p == 0 || p > DW || f >= unsigned'(fr_l.size())) return 1'b0;
        w = (b >= SW) ? fr_r[f] : fr_l[f];
        return w[DW - p];
    endfunction

    // Walks one frame from its first cycle, gathering SDout/LRCLK at SCLK rising edges.
    task automatic collect_frame(output logic [2*SW-1:0] rx, output logic [2*SW-1:0] lr,
                                 output int unsigned ns);
        logic prev = 1'b0;
        rx = '0;
        lr = '0;
        ns = 0;
        for (int n = 0; n < int'(FRAME); n++) begin
            if (SCLK && !prev) begin
                rx = {rx[2*SW-2:0], SDout};
                lr = {lr[2*SW-2:0], LRCLK};
            end
            if (frame_strobe) ns++;
            prev = SCLK;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int unsigned first_fs = 0;
        bit          seen = 1'b0;
        lft_in = '0;
        rht_in = '0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({SCLK, LRCLK, SDout, frame_strobe} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000", {SCLK, LRCLK, SDout, frame_strobe});
        end
        rst = 1'b0;
        for (int n = 1; n <= int'(FRAME); n++) begin
            @(negedge clk);
            total++;
            if (SCLK !== ((n % SD) >= SD / 2)) begin
                bad++;
                $display("FAIL reset_sclk n=%0d got=%b exp=%b", n, SCLK, (n % SD) >= SD / 2);
            end
            total++;
            if (LRCLK !== ((n % FRAME) >= FRAME / 2)) begin
                bad++;
                $display("FAIL reset_lrclk n=%0d got=%b exp=%b", n, LRCLK, (n % FRAME) >= FRAME / 2);
            end
            total++;
            if (SDout !== 1'b0) begin
                bad++;
                $display("FAIL frame0_sdout n=%0d got=%b exp=0", n, SDout);
            end
            if (frame_strobe && !seen) begin
                seen     = 1'b1;
                first_fs = n;
            end
        end
        total++;
        if (first_fs != FRAME - 1) begin
            bad++;
            $display("FAIL first_strobe got=%0d exp=%0d", first_fs, FRAME - 1);
        end
    endtask

    task automatic test_pattern();
        logic [2*SW-1:0] rx, lr;
        int unsigned     ns;
        lft_in = 16'hA5C3;
        rht_in = 16'h8001;
        collect_frame(rx, lr, ns);
        total++;
        if (rx !== '0) begin
            bad++;
            $display("FAIL pattern_early got=%h exp=0", rx);
        end
        collect_frame(rx, lr, ns);
        total++;
        if (rx !== PAT) begin
            bad++;
            $display("FAIL pattern_data got=%h exp=%h", rx, PAT);
        end
        total++;
        if (lr !== {{SW{1'b0}}, {SW{1'b1}}}) begin
            bad++;
            $display("FAIL pattern_lrclk got=%h exp=%h", lr, {{SW{1'b0}}, {SW{1'b1}}});
        end
        total++;
        if (ns != 1) begin
            bad++;
            $display("FAIL pattern_strobes got=%0d exp=1", ns);
        end
    endtask

    task automatic test_glitch();
        logic [2*SW-1:0] rx = '0, lr;
        logic            prev = 1'b0;
        int unsigned     ns;
        for (int n = 0; n < int'(FRAME); n++) begin
            if (SCLK && !prev) rx = {rx[2*SW-2:0], SDout};
            prev = SCLK;
            if (n == 128) lft_in = 16'hFFFF;
            if (n == 200) lft_in = 16'hA5C3;
            @(negedge clk);
        end
        total++;
        if (rx !== PAT) begin
            bad++;
            $display("FAIL glitch_inflight got=%h exp=%h", rx, PAT);
        end
        collect_frame(rx, lr, ns);
        total++;
        if (rx !== PAT) begin
            bad++;
            $display("FAIL glitch_next got=%h exp=%h", rx, PAT);
        end
    endtask

`ifdef I2S_TX_MUTE_EN
    task automatic test_mute();
        logic [2*SW-1:0] rx, lr;
        int unsigned     ns;
        mute_v = 1'b1;
        lft_in = 16'h7FFF;
        rht_in = 16'h1234;
        collect_frame(rx, lr, ns);
        total++;
        if (rx !== PAT) begin
            bad++;
            $display("FAIL mute_inflight got=%h exp=%h", rx, PAT);
        end
        total++;
        if (ns != 1) begin
            bad++;
            $display("FAIL mute_strobe got=%0d exp=1", ns);
        end
        mute_v = 1'b0;
        collect_frame(rx, lr, ns);
        total++;
        if (rx !== '0) begin
            bad++;
            $display("FAIL mute_zero got=%h exp=0", rx);
        end
        collect_frame(rx, lr, ns);
        total++;
        if (rx !== {1'b0, 16'h7FFF, 15'h0000, 1'b0, 16'h1234, 15'h0000}) begin
            bad++;
            $display("FAIL unmute_data got=%h exp=%h", rx,
                     {1'b0, 16'h7FFF, 15'h0000, 1'b0, 16'h1234, 15'h0000});
        end
    endtask
`endif

    task automatic test_mid_reset();
        int unsigned n = 0;
        for (int g = 0; g < int'(FRAME) && (k % FRAME) != 160; g++) @(negedge clk);
        total++;
        if (LRCLK !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_lrclk got=%b exp=1", LRCLK);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({SCLK, LRCLK, SDout, frame_strobe} !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_outputs got=%b exp=0000", {SCLK, LRCLK, SDout, frame_strobe});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        while (!frame_strobe && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != FRAME - 1) begin
            bad++;
            $display("FAIL midreset_strobe got=%0d exp=%0d", n, FRAME - 1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int fr = 0; fr < 100; fr++) begin
            logic [2*SW-1:0] rx = '0;
            logic [2*SW-1:0] ex;
            logic            prev = 1'b0;
            int unsigned     f0 = k / FRAME;
            int unsigned     c  = $urandom_range(0, FRAME - 1);
            for (int n = 0; n < int'(FRAME); n++) begin
                total++;
                if (SCLK !== ((k % SD) >= SD / 2)) begin
                    bad++;
                    $display("FAIL rnd_sclk k=%0d got=%b exp=%b", k, SCLK, (k % SD) >= SD / 2);
                end
                total++;
                if (LRCLK !== (((k / SD) % (2 * SW)) >= SW)) begin
                    bad++;
                    $display("FAIL rnd_lrclk k=%0d got=%b exp=%b", k, LRCLK, ((k / SD) % (2 * SW)) >= SW);
                end
                total++;
                if (SDout !== exp_sd(k)) begin
                    bad++;
                    $display("FAIL rnd_sdout k=%0d got=%b exp=%b", k, SDout, exp_sd(k));
                end
                total++;
                if (frame_strobe !== ((k % FRAME) == FRAME - 1)) begin
                    bad++;
                    $display("FAIL rnd_strobe k=%0d got=%b exp=%b", k, frame_strobe, (k % FRAME) == FRAME - 1);
                end
                if (SCLK && !prev) rx = {rx[2*SW-2:0], SDout};
                prev = SCLK;
                if (n == int'(c)) begin
                    lft_in = sample_t'($urandom);
                    rht_in = sample_t'($urandom);
`ifdef I2S_TX_MUTE_EN
                    mute_v = ($urandom_range(0, 3) == 0);
`endif
                end
                @(negedge clk);
            end
            ex = {1'b0, fr_l[f0], {(SW-DW-1){1'b0}}, 1'b0, fr_r[f0], {(SW-DW-1){1'b0}}};
            total++;
            if (rx !== ex) begin
                bad++;
                $display("FAIL rnd_frame f=%0d got=%h exp=%h", f0, rx, ex);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pattern();
        test_glitch();
`ifdef I2S_TX_MUTE_EN
        test_mute();
`endif
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
